// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris piece pipeline.
// The piece IDs match the 2-bit rng output space.
package tetris_pkg;

  localparam int unsigned PIECE_W = 2;

  localparam logic [PIECE_W-1:0] PIECE_I = 2'd0;
  localparam logic [PIECE_W-1:0] PIECE_O = 2'd1;
  localparam logic [PIECE_W-1:0] PIECE_T = 2'd2;
  localparam logic [PIECE_W-1:0] PIECE_L = 2'd3;

  typedef enum logic {
    SAMPLE,
    REROLL
  } refill_st_e;

endpackage

// File: rtl/piece_fifo.sv
// Circular preview buffer of piece IDs with a registered occupancy count.
// The caller never pushes when full and never pops when empty.
module piece_fifo #(
  parameter int unsigned QDEPTH = 3,
  parameter int unsigned W      = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [2:0]   count_o
);

  localparam int unsigned PW = $clog2(QDEPTH);

  logic [W-1:0]  mem_q [QDEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [2:0]    cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) rd_q <= ptr_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/piece_scheduler.sv
// Fills a preview queue from the registered rng sample with a bounded anti-repeat
// reroll, and hands the head to the game controller over a req/ack handshake.
module piece_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned QDEPTH     = 3,
  parameter int unsigned PIECE_W    = tetris_pkg::PIECE_W,
  parameter int unsigned MAX_REROLL = 1
) (
  input  logic               clka,
  input  logic               restart,
  input  logic [PIECE_W-1:0] random,
  input  logic               spawn_req,
  output logic               spawn_ack,
  output logic [PIECE_W-1:0] spawn_piece,
  output logic [PIECE_W-1:0] next_piece,
  output logic [2:0]         q_count,
  output logic               ready
);

  localparam int unsigned RcW = (MAX_REROLL > 0) ? $clog2(MAX_REROLL + 1) : 1;

  refill_st_e         state_q;
  logic [PIECE_W-1:0] samp_q;
  logic               samp_vld_q;
  logic [PIECE_W-1:0] last_piece_q;
  logic               last_valid_q;
  logic [RcW-1:0]     reroll_cnt_q;
  logic               ack_q;
  logic [PIECE_W-1:0] piece_q;

  logic               room, repeat_hit, push, pop;
  logic [PIECE_W-1:0] head;
  logic [2:0]         count;

  // samp_vld_q keeps the reset value of samp_q from being pushed as a real sample.
  always_comb begin
    room       = samp_vld_q && (count < 3'(QDEPTH));
    repeat_hit = last_valid_q && (samp_q == last_piece_q) &&
                 (reroll_cnt_q < RcW'(MAX_REROLL));
    push       = (state_q == SAMPLE) && room && !repeat_hit;
    pop        = spawn_req && (count != 3'd0) && !ack_q;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q      <= SAMPLE;
      samp_q       <= '0;
      samp_vld_q   <= 1'b0;
      last_piece_q <= '0;
      last_valid_q <= 1'b0;
      reroll_cnt_q <= '0;
      ack_q        <= 1'b0;
      piece_q      <= '0;
    end else begin
      samp_q     <= random;
      samp_vld_q <= 1'b1;
      ack_q      <= pop;
      piece_q    <= pop ? head : '0;
      case (state_q)
        SAMPLE: begin
          if (room && repeat_hit) begin
            reroll_cnt_q <= reroll_cnt_q + 1'b1;
            state_q      <= REROLL;
          end else if (room) begin
            last_piece_q <= samp_q;
            last_valid_q <= 1'b1;
            reroll_cnt_q <= '0;
          end
        end
        REROLL:  state_q <= SAMPLE;
        default: state_q <= SAMPLE;
      endcase
    end
  end

  piece_fifo #(
    .QDEPTH (QDEPTH),
    .W      (PIECE_W)
  ) u_fifo (
    .clk_i   (clka),
    .rst_i   (restart),
    .push_i  (push),
    .data_i  (samp_q),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count)
  );

  assign spawn_ack   = ack_q;
  assign spawn_piece = piece_q;
  assign next_piece  = (count == 3'd0) ? '0 : head;
  assign q_count     = count;
  assign ready       = (count != 3'd0);

endmodule

// File: tb/tb_piece_scheduler.sv
// Randomised bench for piece_scheduler with a queue-based reference model and
// an ack-driven scoreboard.
module tb_piece_scheduler;

  localparam int QDEPTH     = 3;
  localparam int MAX_REROLL = 1;

  logic       clka = 1'b0;
  logic       restart = 1'b1;
  logic [1:0] random = 2'd0;
  logic       spawn_req = 1'b0;
  logic       spawn_ack;
  logic [1:0] spawn_piece;
  logic [1:0] next_piece;
  logic [2:0] q_count;
  logic       ready;

  piece_scheduler #(
    .QDEPTH     (QDEPTH),
    .PIECE_W    (2),
    .MAX_REROLL (MAX_REROLL)
  ) dut (
    .clka        (clka),
    .restart     (restart),
    .random      (random),
    .spawn_req   (spawn_req),
    .spawn_ack   (spawn_ack),
    .spawn_piece (spawn_piece),
    .next_piece  (next_piece),
    .q_count     (q_count),
    .ready       (ready)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;

  // Reference model state: sample seen last edge (-1 = none), preview queue,
  // last pushed piece (-1 = none), rerolls used, pending wait cycle, ack flag.
  int m_samp;
  int m_q[$];
  int m_last;
  int m_rr;
  bit m_wait;
  bit m_ack;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_samp = -1;
    m_q.delete();
    m_last = -1;
    m_rr   = 0;
    m_wait = 1'b0;
    m_ack  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input int rnd, input bit req);
    int  cnt;
    bit  do_pop;
    int  popped;
    cnt    = m_q.size();
    do_pop = req && (cnt > 0) && !m_ack;
    popped = 0;
    if (do_pop) popped = m_q.pop_front();
    if (m_wait) begin
      m_wait = 1'b0;
    end else if (m_samp >= 0 && cnt < QDEPTH) begin
      if (m_last == m_samp && m_rr < MAX_REROLL) begin
        m_rr++;
        m_wait = 1'b1;
      end else begin
        m_q.push_back(m_samp);
        m_last = m_samp;
        m_rr   = 0;
      end
    end
    m_ack = do_pop;
    if (do_pop) exp_q.push_back(popped);
    m_samp = rnd;
  endtask

  // Drives inputs at a negedge, steps the model at the posedge, returns at the next negedge.
  task automatic cycle(input logic [1:0] rnd, input logic req);
    random    = rnd;
    spawn_req = req;
    @(posedge clka);
    model_step(int'(rnd), req);
    @(negedge clka);
  endtask

  task automatic do_reset();
    restart = 1'b1;
    model_reset();
    @(posedge clka);
    @(negedge clka);
    restart = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, int'(spawn_ack), 0);
    check({tag, "_piece"}, int'(spawn_piece), 0);
    check({tag, "_next"}, int'(next_piece), 0);
    check({tag, "_count"}, int'(q_count), 0);
    check({tag, "_ready"}, int'(ready), 0);
  endtask

  // Asynchronous restart between clock edges; outputs must clear before any edge.
  task automatic restart_mid();
    #2;
    restart = 1'b1;
    model_reset();
    #1;
    check_zero("async_rst");
    @(posedge clka);
    @(negedge clka);
    restart = 1'b0;
  endtask

  // Monitor: compares visible state each cycle and pops the scoreboard on every ack.
  initial begin
    forever begin
      @(negedge clka);
      #1;
      check("q_count", int'(q_count), m_q.size());
      check("next_piece", int'(next_piece), (m_q.size() > 0) ? m_q[0] : 0);
      check("ready", int'(ready), int'(m_q.size() > 0));
      check("spawn_ack", int'(spawn_ack), int'(m_ack));
      if (spawn_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          check("spawn_piece", int'(spawn_piece), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit         req_r;
    logic [1:0] rnd;
    model_reset();
    #1;
    check_zero("reset");
    @(negedge clka);
    @(negedge clka);
    restart = 1'b0;

    // Reset fill with a constant source: first push on the 2nd edge.
    cycle(2'd2, 1'b0);
    check("fill1_count", int'(q_count), 0);
    cycle(2'd2, 1'b0);
    check("fill2_count", int'(q_count), 1);
    check("fill2_next", int'(next_piece), 2);
    check("fill2_ready", int'(ready), 1);
    for (int i = 0; i < 6; i++) cycle(2'd2, 1'b0);
    check("fill8_count", int'(q_count), 3);

    // Anti-repeat: 1,1,3 leaves [1,3] after one reroll wait.
    do_reset();
    cycle(2'd1, 1'b0);
    cycle(2'd1, 1'b0);
    cycle(2'd3, 1'b0);
    cycle(2'd3, 1'b0);
    cycle(2'd3, 1'b0);
    check("norep_count", int'(q_count), 2);
    check("norep_next", int'(next_piece), 1);

    // Stuck source: pushes on edges 2 and 5, reroll on 6, then restart mid-reroll.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(2'd0, 1'b0);
    check("stuck_count", int'(q_count), 2);
    restart_mid();
    for (int i = 0; i < 4; i++) cycle(2'd1, 1'b0);

    // Handshake on a full [2,1,3] queue.
    do_reset();
    cycle(2'd2, 1'b0);
    cycle(2'd1, 1'b0);
    cycle(2'd3, 1'b0);
    cycle(2'd3, 1'b0);
    check("full_count", int'(q_count), 3);
    check("full_next", int'(next_piece), 2);
    cycle(2'd0, 1'b1);
    check("hs_ack", int'(spawn_ack), 1);
    check("hs_piece", int'(spawn_piece), 2);
    check("hs_next", int'(next_piece), 1);
    check("hs_count", int'(q_count), 2);
    cycle(2'd0, 1'b0);
    check("hs_refill", int'(q_count), 3);
    check("hs_single", int'(spawn_ack), 0);

    // Request held across restart on an empty queue.
    spawn_req = 1'b1;
    random    = 2'd3;
    do_reset();
    cycle(2'd3, 1'b1);
    cycle(2'd3, 1'b1);
    check("empty_noack", int'(spawn_ack), 0);
    cycle(2'd3, 1'b1);
    check("empty_ack", int'(spawn_ack), 1);
    check("empty_piece", int'(spawn_piece), 3);
    cycle(2'd3, 1'b0);

    // Randomised traffic with a well-behaved controller and occasional restarts.
    req_r = 1'b0;
    rnd   = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 0) rnd = 2'($urandom_range(0, 3));
      if (req_r && m_ack) begin
        if ($urandom_range(0, 3) != 0) req_r = 1'b0;
      end else if (!req_r && $urandom_range(0, 9) < 3) begin
        req_r = 1'b1;
      end
      cycle(rnd, req_r);
      if ($urandom_range(0, 199) == 0) restart_mid();
    end
    spawn_req = 1'b0;
    cycle(rnd, 1'b0);
    cycle(rnd, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
